cache_ctrl_4way: RTL

// Sequencing controller for the 4-way set-associative cache built around HitMissLogic (36-bit tags).
// - Accepts one CPU load/store at a time and drives the lookup.
// - Owns the per-way valid/dirty bits and the per-set round-robin victim pointers.
// - Runs write-back and refill transactions against the next-level memory.
// - Tag and data arrays are external; this block drives their write strobes and way select.

---
 rtl/cache_ctrl_4way_if.sv | 45 ++++
 rtl/cache_ctrl_4way.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_4way_if.sv
// Bus bundle between the 4-way cache sequencer and its surroundings:
// CPU request port, HitMissLogic, tag/data array controls and next-level memory.
interface cache_ctrl_4way_if #(
  parameter int ADDR_W   = 48,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

  // CPU side
  logic               cpu_req;
  logic               cpu_we;
  logic [ADDR_W-1:0]  cpu_addr;
  logic               cpu_ready;
  // HitMissLogic
  logic               hit;
  logic [1:0]         hit_way;
  logic [3:0]         vbit;
  // Tag/data arrays
  logic [INDEX_W-1:0] set_idx;
  logic [1:0]         way_sel;
  logic [TAG_W-1:0]   victim_tag;
  logic               tag_we;
  logic               data_we;
  logic               fill_sel;
  // Next-level memory
  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;

  // The controller: answers CPU requests, drives arrays and memory.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, hit, hit_way, victim_tag, mem_ack,
    output cpu_ready, vbit, set_idx, way_sel, tag_we, data_we, fill_sel,
           mem_req, mem_we, mem_addr
  );

  // The environment: CPU, HitMissLogic, arrays and memory model.
  modport master (
    output cpu_req, cpu_we, cpu_addr, hit, hit_way, victim_tag, mem_ack,
    input  cpu_ready, vbit, set_idx, way_sel, tag_we, data_we, fill_sel,
           mem_req, mem_we, mem_addr
  );
endinterface

// File: rtl/cache_ctrl_4way.sv
// Sequencing controller for a 4-way set-associative cache.
// Handles one CPU load/store at a time, owns valid/dirty bits and per-set
// round-robin victim pointers, and runs write-back/refill against memory.
module cache_ctrl_4way #(
  parameter int ADDR_W   = 48,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  cache_ctrl_4way_if.slave bus
);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_W   = ADDR_W - OFFSET_W;
  localparam int NUM_SETS = 1 << INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_REFILL,
    S_FILLDONE
  } state_t;

  state_t             state;
  logic               req_we;
  logic [LINE_W-1:0]  req_line;   // latched request address without offset
  logic [1:0]         victim;
  logic [3:0]         valid  [NUM_SETS];
  logic [3:0]         dirty  [NUM_SETS];
  logic [1:0]         rr_ptr [NUM_SETS];

  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic [3:0]         set_valid;
  logic [3:0]         set_dirty;
  logic [1:0]         set_rr;
  logic [1:0]         miss_victim;
  logic               use_rr;

  assign req_index = req_line[INDEX_W-1:0];
  assign req_tag   = req_line[LINE_W-1:INDEX_W];
  assign set_valid = valid[req_index];
  assign set_dirty = dirty[req_index];
  assign set_rr    = rr_ptr[req_index];

  // Offset bits select a word inside the line; the sequencer only moves whole lines.
  logic unused_offset;
  assign unused_offset = ^bus.cpu_addr[OFFSET_W-1:0];

  // Victim choice on a miss: lowest-numbered invalid way, otherwise the set's round-robin pointer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    miss_victim = set_rr;
    use_rr      = 1'b1;
    if (!set_valid[0]) begin
      miss_victim = 2'd0;
      use_rr      = 1'b0;
    end else if (!set_valid[1]) begin
      miss_victim = 2'd1;
      use_rr      = 1'b0;
    end else if (!set_valid[2]) begin
      miss_victim = 2'd2;
      use_rr      = 1'b0;
    end else if (!set_valid[3]) begin
      miss_victim = 2'd3;
      use_rr      = 1'b0;
    end
  end

  // Output decode: array/memory controls follow the state, hit and ack responses act in the same cycle.
  always_comb begin
    bus.cpu_ready = 1'b0;
    bus.vbit      = set_valid;
    bus.set_idx   = req_index;
    bus.way_sel   = 2'd0;
    bus.tag_we    = 1'b0;
    bus.data_we   = 1'b0;
    bus.fill_sel  = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    unique case (state)
      S_LOOKUP: begin
        if (bus.hit) begin
          bus.way_sel   = bus.hit_way;
          bus.data_we   = req_we;
          bus.cpu_ready = 1'b1;
        end else begin
          // Present the victim so its tag is already on victim_tag.
          bus.way_sel = miss_victim;
        end
      end
      S_WRITEBACK: begin
        bus.way_sel  = victim;
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = {bus.victim_tag, req_index, {OFFSET_W{1'b0}}};
      end
      S_REFILL: begin
        bus.way_sel  = victim;
        bus.mem_req  = 1'b1;
        bus.mem_addr = {req_line, {OFFSET_W{1'b0}}};
        if (bus.mem_ack) begin
          bus.tag_we   = 1'b1;
          bus.data_we  = 1'b1;
          bus.fill_sel = 1'b1;
        end
      end
      S_FILLDONE: bus.way_sel = victim;
      default: ;
    endcase
  end

  // Sequencer state, latched request and per-set valid/dirty/round-robin bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      req_we   <= 1'b0;
      req_line <= '0;
      victim   <= 2'd0;
      // NOTE: valid/dirty/rr_ptr are real flops, not RAM, because reset must invalidate the whole cache at once.
      for (int s = 0; s < NUM_SETS; s++) begin
        valid[s]  <= '0;
        dirty[s]  <= '0;
        rr_ptr[s] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every read sees the pre-edge value.
      unique case (state)
        S_IDLE: begin
          if (bus.cpu_req) begin
            req_we   <= bus.cpu_we;
            req_line <= bus.cpu_addr[ADDR_W-1:OFFSET_W];
            state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (bus.hit) begin
            if (req_we) dirty[req_index][bus.hit_way] <= 1'b1;
            state <= S_IDLE;
          end else begin
            victim <= miss_victim;
            if (use_rr) rr_ptr[req_index] <= set_rr + 2'd1;
            if (set_valid[miss_victim] && set_dirty[miss_victim]) state <= S_WRITEBACK;
            else                                                  state <= S_REFILL;
          end
        end
        S_WRITEBACK: begin
          if (bus.mem_ack) begin
            dirty[req_index][victim] <= 1'b0;
            state                    <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (bus.mem_ack) begin
            valid[req_index][victim] <= 1'b1;
            state                    <= S_FILLDONE;
          end
        end
        S_FILLDONE: state <= S_LOOKUP;
        default:    state <= S_IDLE;
      endcase
    end
  end

  // HitMissLogic must never report a hit on a way whose valid bit is clear.
  hit_on_valid_way: assert property (@(posedge clk) disable iff (reset)
    (state == S_LOOKUP && bus.hit) |-> set_valid[bus.hit_way]);

endmodule
